frame_logger: RTL and testbench
===============================

Name: frame_logger

Overview:
Parametrised successor to the IAGC telemetry logger. It snapshots a wide packed bus of N_WORDS telemetry words and serialises them over UART 8N1 as a framed packet. Each packet is a header byte, the payload bytes, then an XOR checksum byte. Frames start either periodically (every TICKS cycles) or on an external trigger. The block sits between the IAGC datapath and the board UART pin, and adds overrun detection and frame-done signalling.

Parameters:
CLK_FREQUENCY, 100_000_000, system clock frequency in Hz
UART_FREQUENCY, 9_200, baud rate in bit/s; bit period DIV = CLK_FREQUENCY/UART_FREQUENCY, truncated, must be >= 2
N_WORDS, 4, number of telemetry words per frame, 1..16
WORD_BYTES, 2, bytes per word, 1..4
TICKS, 300000, periodic-mode frame interval in clock cycles, >= 1
HEADER, 8'hA5, frame sync byte

Ports:
i_clock  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_enable  in  1  allows new frames to start
i_mode  in  1  0 = periodic, 1 = triggered
i_trigger  in  1  frame request in triggered mode; sampled high on a clock edge
i_data  in  N_WORDS*WORD_BYTES*8  packed telemetry; word 0 in the LSBs
o_txBit  out  1  UART serial output, idles high
o_busy  out  1  high from frame start until the last stop bit ends
o_frameDone  out  1  one-cycle pulse after the checksum stop bit
o_overrun  out  1  sticky; a request arrived while busy

Behaviour:
- Reset values: o_txBit=1, o_busy=0, o_frameDone=0, o_overrun=0. Timer, FSM, byte index and snapshot all clear asynchronously. Reset mid-frame aborts the frame and o_txBit returns high immediately.
- FRAME_BYTES = N_WORDS*WORD_BYTES + 2.
- Byte order: HEADER, then payload bytes from i_data[7:0] upward (each word little-endian, word 0 first), then CHK. CHK = XOR of HEADER and all payload bytes.
- Each UART byte is 8N1: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts DIV cycles, so one byte = 10*DIV cycles.
- Periodic timer:
  - Counts 0..TICKS-1 while i_enable=1 and i_mode=0, and wraps.
  - A request is generated on the cycle the count equals TICKS-1.
  - The timer is held at 0 while i_enable=0 or i_mode=1.
- Triggered mode: a request is generated on each edge where i_trigger=1 (level-sampled, not edge-detected).
- Request accepted (state IDLE and i_enable=1), at edge k:
  - i_data is captured into the snapshot register.
  - o_busy goes to 1.
  - The start bit of HEADER appears on o_txBit from edge k+1.
- Request while busy: it is dropped, no frame is queued, and o_overrun is set to 1 until reset. The current frame is unaffected.
- FSM states:
  - IDLE: waits for an accepted request, then goes to LOAD.
  - LOAD: selects byte[idx] and pulses start to uart_tx, then goes to SEND.
  - SEND: waits for uart_tx done. If idx < FRAME_BYTES-1, idx increments and the FSM returns to LOAD; otherwise it goes to DONE.
  - DONE: pulses o_frameDone for one cycle, sets o_busy to 0, and returns to IDLE.
- The gap between one stop bit ending and the next start bit is at most 2 cycles.
- The checksum is accumulated during the frame and is not recomputed at the end.
- i_enable falling mid-frame: the current frame completes, and no new frame starts.
- i_mode change mid-frame: takes effect only for new requests. The timer restarts from 0 on entering periodic mode.
- i_data changes during a frame do not affect the frame; only the snapshot is transmitted.
- A request can be accepted at the edge after DONE, so back-to-back frames are allowed.

Decomposition:
- Package frame_logger_pkg holds:
  - FSM state encoding (IDLE, LOAD, SEND, DONE)
  - UART_DATA_SIZE=8
  - default HEADER
  - a function computing FRAME_BYTES
- One sub-module, uart_tx (parameters CLK_FREQUENCY, UART_FREQUENCY):
  - ports i_clock, i_reset, i_start, i_data[7:0], o_txBit, o_busy, o_done
  - o_done is a one-cycle pulse at the end of the stop bit.
- The bench reuses the existing uart_rx; its rst_n is driven by ~reset.

Test Plan:
All scenarios use CLK_FREQUENCY=1_000_000, UART_FREQUENCY=100_000 (DIV=10), N_WORDS=2, WORD_BYTES=2.
1. Triggered single frame: i_data=32'h00F0_000F, one i_trigger pulse -> uart_rx receives A5 0F 00 F0 00 5A. o_frameDone pulses once, about 600 cycles later. o_overrun stays 0.
2. Snapshot hold: trigger with i_data=32'h1234_5678, change i_data to 0 one cycle later -> receives A5 78 56 34 12 (A5^78^56^34^12).
3. Periodic, TICKS=1000: i_enable=1, i_mode=0, i_data=32'h0000_0001 -> frames start 1000 cycles apart, each A5 01 00 00 00 A4. No overrun.
4. Overrun: trigger, then trigger again 100 cycles later -> exactly one frame is received and o_overrun=1. A third trigger after o_busy falls produces a second frame, and o_overrun stays 1.
5. Reset mid-frame: assert i_reset during the third byte -> o_txBit=1 and o_busy=0 without waiting for a clock edge. After release plus a trigger, a complete, correct frame follows.
6. Enable gating: i_enable=0 with triggers and periodic mode -> o_txBit stays 1 and no frames. Dropping i_enable mid-frame -> that frame still completes.

Source files
------------

// File: rtl/frame_logger_pkg.sv
// frame_logger_pkg
// Shared definitions for the telemetry frame logger: FSM state encoding,
// UART character size, default sync byte and the frame length helper.
package frame_logger_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int UART_DATA_SIZE = 8;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

    // Header + payload + checksum.
    function automatic int frame_bytes(input int n_words, input int word_bytes);
        return n_words * word_bytes + 2;
    endfunction

endpackage

// File: rtl/frame_logger_uart_tx.sv
// uart_tx
// 8N1 UART transmitter. One character per i_start pulse while idle.
// Ports:
//   i_clock, i_reset : clock, asynchronous active-high reset
//   i_start          : load i_data and begin a character (ignored while busy)
//   i_data           : character to send, LSB first
//   o_txBit          : serial line, idles high
//   o_busy           : a character is in flight
//   o_done           : one-cycle pulse during the final cycle of the stop bit
module uart_tx
    import frame_logger_pkg::*;
#(
    parameter int CLK_FREQUENCY  = 100_000_000,
    parameter int UART_FREQUENCY = 9_200
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic [UART_DATA_SIZE-1:0] i_data,
    output logic                      o_txBit,
    output logic                      o_busy,
    output logic                      o_done
);

    localparam int DIV   = CLK_FREQUENCY / UART_FREQUENCY;
    localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;

    logic                      active_q, active_d;
    logic                      tx_q, tx_d;
    logic [UART_DATA_SIZE:0]   shreg_q, shreg_d;
    logic [DIV_W-1:0]          div_cnt_q, div_cnt_d;
    logic [3:0]                bit_cnt_q, bit_cnt_d;
    logic                      bit_end;

    assign bit_end = (div_cnt_q == DIV_W'(DIV - 1));

    always_comb begin
        active_d  = active_q;
        tx_d      = tx_q;
        shreg_d   = shreg_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        if (!active_q) begin
            if (i_start) begin
                active_d  = 1'b1;
                tx_d      = 1'b0;                 // start bit
                shreg_d   = {1'b1, i_data};       // data bits then stop bit
                div_cnt_d = '0;
                bit_cnt_d = '0;
            end
        end else if (bit_end) begin
            div_cnt_d = '0;
            if (bit_cnt_q == 4'd9) begin
                active_d = 1'b0;
                tx_d     = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                tx_d      = shreg_q[0];
                shreg_d   = {1'b1, shreg_q[UART_DATA_SIZE:1]};
            end
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            active_q  <= 1'b0;
            tx_q      <= 1'b1;
            shreg_q   <= '1;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            active_q  <= active_d;
            tx_q      <= tx_d;
            shreg_q   <= shreg_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign o_txBit = tx_q;
    assign o_busy  = active_q;
    assign o_done  = active_q && bit_end && (bit_cnt_q == 4'd9);

endmodule

// File: rtl/frame_logger.sv
// frame_logger
// Snapshots N_WORDS telemetry words and sends them over UART 8N1 as
// HEADER, payload bytes (i_data[7:0] first), XOR checksum.
// Frames are requested periodically (every TICKS cycles) or by i_trigger.
// Ports:
//   i_clock, i_reset : clock, asynchronous active-high reset
//   i_enable         : allows new frames to start
//   i_mode           : 0 = periodic, 1 = triggered
//   i_trigger        : level-sampled frame request in triggered mode
//   i_data           : packed telemetry, word 0 in the LSBs
//   o_txBit          : UART serial output, idles high
//   o_busy           : frame in progress
//   o_frameDone      : one-cycle pulse after the checksum stop bit
//   o_overrun        : sticky, a request arrived while busy
module frame_logger
    import frame_logger_pkg::*;
#(
    parameter int          CLK_FREQUENCY  = 100_000_000,
    parameter int          UART_FREQUENCY = 9_200,
    parameter int          N_WORDS        = 4,
    parameter int          WORD_BYTES     = 2,
    parameter int          TICKS          = 300000,
    parameter logic [7:0]  HEADER         = DEFAULT_HEADER
) (
    input  logic                              i_clock,
    input  logic                              i_reset,
    input  logic                              i_enable,
    input  logic                              i_mode,
    input  logic                              i_trigger,
    input  logic [N_WORDS*WORD_BYTES*8-1:0]   i_data,
    output logic                              o_txBit,
    output logic                              o_busy,
    output logic                              o_frameDone,
    output logic                              o_overrun
);

    localparam int PAYLOAD     = N_WORDS * WORD_BYTES;
    localparam int FRAME_BYTES = frame_bytes(N_WORDS, WORD_BYTES);
    localparam int IDX_W       = $clog2(FRAME_BYTES);
    localparam int TMR_W       = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

    state_e                           state_q, state_d;
    logic [TMR_W-1:0]                 timer_q, timer_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [PAYLOAD*8-1:0]             snap_q, snap_d;
    logic [7:0]                       chk_q, chk_d;
    logic                             overrun_q, overrun_d;

    logic                             periodic_on;
    logic                             timer_wrap;
    logic                             request;
    logic                             frame_active;
    logic [UART_DATA_SIZE-1:0]        tx_byte;
    logic                             uart_start;
    logic                             uart_done;
    logic                             uart_busy;

    // Periodic timer: runs only in enabled periodic mode, otherwise parked
    // at 0 so entering periodic mode always starts a full interval.
    assign periodic_on = i_enable && !i_mode;
    assign timer_wrap  = (timer_q == TMR_W'(TICKS - 1));

    always_comb begin
        timer_d = '0;
        if (periodic_on && !timer_wrap) begin
            timer_d = timer_q + TMR_W'(1);
        end
    end

    assign request      = (periodic_on && timer_wrap) || (i_mode && i_trigger);
    assign frame_active = (state_q == ST_LOAD) || (state_q == ST_SEND);

    // Byte currently addressed by idx: header, payload, then checksum.
    always_comb begin
        tx_byte = HEADER;
        if (idx_q == LAST_IDX) begin
            tx_byte = chk_q;
        end else begin
            for (int b = 0; b < PAYLOAD; b++) begin
                if (idx_q == IDX_W'(b + 1)) begin
                    tx_byte = snap_q[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        snap_d     = snap_q;
        chk_d      = chk_q;
        overrun_d  = overrun_q || (request && frame_active);
        uart_start = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // DONE also accepts, which allows back-to-back frames.
                state_d = ST_IDLE;
                if (request && i_enable) begin
                    state_d = ST_LOAD;
                    snap_d  = i_data;
                    idx_d   = '0;
                    chk_d   = HEADER;
                end
            end
            ST_LOAD: begin
                uart_start = 1'b1;
                state_d    = ST_SEND;
                // Fold payload bytes into the running checksum as they go out.
                if (idx_q != '0 && idx_q != LAST_IDX) begin
                    chk_d = chk_q ^ tx_byte;
                end
            end
            ST_SEND: begin
                if (uart_done) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            idx_q     <= '0;
            snap_q    <= '0;
            chk_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            chk_q     <= chk_d;
            overrun_q <= overrun_d;
        end
    end

    uart_tx #(
        .CLK_FREQUENCY  (CLK_FREQUENCY),
        .UART_FREQUENCY (UART_FREQUENCY)
    ) u_uart_tx (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_start (uart_start),
        .i_data  (tx_byte),
        .o_txBit (o_txBit),
        .o_busy  (uart_busy),
        .o_done  (uart_done)
    );

    assign o_busy      = frame_active;
    assign o_frameDone = (state_q == ST_DONE);
    assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_frame_logger.sv
// Bench for frame_logger: serial receiver, byte scoreboard fed by a frame
// model, and directed plus randomized frame scenarios.
module tb_frame_logger;

    localparam int CLK_F  = 1_000_000;
    localparam int UART_F = 100_000;
    localparam int DIV    = 10;
    localparam int NW     = 2;
    localparam int WB     = 2;
    localparam int TICKS  = 1000;
    localparam int NB     = NW * WB;
    localparam int W      = NB * 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         mode;
    logic         trig;
    logic [W-1:0] data;
    logic         tx;
    logic         busy;
    logic         done;
    logic         ovr;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int start_cnt = 0;
    int start_cyc = 0;
    int tx_low_cnt = 0;
    logic busy_prev = 1'b0;

    logic [7:0] exp_q[$];

    frame_logger #(
        .CLK_FREQUENCY  (CLK_F),
        .UART_FREQUENCY (UART_F),
        .N_WORDS        (NW),
        .WORD_BYTES     (WB),
        .TICKS          (TICKS),
        .HEADER         (8'hA5)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_enable    (en),
        .i_mode      (mode),
        .i_trigger   (trig),
        .i_data      (data),
        .o_txBit     (tx),
        .o_busy      (busy),
        .o_frameDone (done),
        .o_overrun   (ovr)
    );

    // Clock / cycle bookkeeping
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        busy_prev <= busy;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (busy && !busy_prev) begin
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc;
        end
        if (tx == 1'b0) tx_low_cnt <= tx_low_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference frame: sync byte, payload low byte first, XOR of everything.
    task automatic push_frame(input logic [W-1:0] d);
        logic [7:0] c;
        c = 8'hA5;
        exp_q.push_back(8'hA5);
        for (int b = 0; b < NB; b++) begin
            exp_q.push_back(d[8*b +: 8]);
            c = c ^ d[8*b +: 8];
        end
        exp_q.push_back(c);
    endtask

    // Serial receiver + scoreboard monitor; samples mid-bit on the falling edge.
    initial begin : rx_monitor
        logic [7:0] sh;
        logic       ok;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                ok = 1'b1;
                sh = '0;
                for (int c = 1; c <= 9 * DIV + DIV / 2; c++) begin
                    @(negedge clk);
                    if (rst) begin
                        ok = 1'b0;
                        break;
                    end
                    if (c % DIV == DIV / 2 && c >= DIV + DIV / 2 && c < 9 * DIV) begin
                        sh = {tx, sh[7:1]};
                    end
                end
                if (ok) begin
                    check("rx_stop_bit", {31'd0, tx}, 32'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_unexpected_byte: got %0h expected none", sh);
                    end else begin
                        check("rx_byte", {24'd0, sh}, {24'd0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    // Driver tasks
    task automatic trig_pulse(output int accept_cyc);
        @(negedge clk);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        accept_cyc = cyc;
    endtask

    task automatic wait_done(input string name, input int budget);
        int base;
        int n;
        base = done_cnt;
        n = 0;
        while (done_cnt == base && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_cnt == base) begin
            errors++;
            $display("FAIL %s: got no frame_done within %0d cycles expected one", name, budget);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : stimulus
        int t_acc;
        int base;
        int lat;
        int prev_start;
        int low_base;
        logic [W-1:0] d;

        rst = 1'b1; en = 1'b0; mode = 1'b1; trig = 1'b0; data = '0;
        idle(3);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_overrun", {31'd0, ovr}, 32'd0);
        rst = 1'b0;
        idle(2);
        en = 1'b1;

        // Triggered single frame with literal expected bytes.
        data = 32'h00F0_000F;
        exp_q.push_back(8'hA5); exp_q.push_back(8'h0F); exp_q.push_back(8'h00);
        exp_q.push_back(8'hF0); exp_q.push_back(8'h00); exp_q.push_back(8'h5A);
        base = done_cnt;
        trig_pulse(t_acc);
        idle(1);
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        wait_done("t1_done", 1000);
        lat = done_cyc - t_acc;
        checks++;
        if (lat < 600 || lat > 615) begin
            errors++;
            $display("FAIL t1_latency: got %0d expected 600..615", lat);
        end
        idle(20);
        check("t1_done_count", done_cnt - base, 1);
        check("t1_overrun", {31'd0, ovr}, 32'd0);
        check("t1_drained", exp_q.size(), 0);

        // Snapshot hold: data changes right after the accepting edge.
        data = 32'h1234_5678;
        push_frame(data);
        trig_pulse(t_acc);
        data = '0;
        wait_done("t2_done", 1000);
        idle(10);
        check("t2_drained", exp_q.size(), 0);

        // Randomized triggered frames with data churn during the frame.
        for (int i = 0; i < 4; i++) begin
            data = $urandom;
            push_frame(data);
            trig_pulse(t_acc);
            idle($urandom_range(1, 300));
            data = $urandom;
            wait_done("rand_done", 1000);
            idle($urandom_range(0, 5));
        end
        idle(10);
        check("rand_drained", exp_q.size(), 0);

        // Overrun: second trigger while busy is dropped.
        data = $urandom;
        push_frame(data);
        base = done_cnt;
        trig_pulse(t_acc);
        idle(98);
        check("t4_no_overrun_yet", {31'd0, ovr}, 32'd0);
        trig_pulse(t_acc);
        idle(1);
        check("t4_overrun_set", {31'd0, ovr}, 32'd1);
        wait_done("t4_done", 1000);
        idle(700);
        check("t4_one_frame", done_cnt - base, 1);
        check("t4_drained", exp_q.size(), 0);
        data = $urandom;
        push_frame(data);
        trig_pulse(t_acc);
        wait_done("t4_second_done", 1000);
        idle(10);
        check("t4_overrun_sticky", {31'd0, ovr}, 32'd1);
        check("t4_second_drained", exp_q.size(), 0);

        // Periodic mode: frames every TICKS cycles.
        data = 32'h0000_0001;
        mode = 1'b0;
        prev_start = 0;
        for (int f = 0; f < 3; f++) begin
            base = start_cnt;
            for (int n = 0; n < 1500 && start_cnt == base; n++) @(negedge clk);
            check("t3_frame_started", start_cnt - base, 1);
            push_frame(data);
            if (f > 0) check("t3_interval", start_cyc - prev_start, TICKS);
            prev_start = start_cyc;
        end
        en = 1'b0;
        wait_done("t3_last_done", 1000);
        idle(10);
        check("t3_drained", exp_q.size(), 0);

        // Enable gating: nothing starts while disabled.
        low_base = tx_low_cnt;
        base = start_cnt;
        mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            trig_pulse(t_acc);
            idle(20);
        end
        mode = 1'b0;
        idle(1200);
        check("t6_no_start", start_cnt - base, 0);
        check("t6_tx_idle", tx_low_cnt - low_base, 0);
        check("t6_no_overrun_change", {31'd0, ovr}, 32'd1);
        // Disable mid-frame: frame still completes.
        mode = 1'b1;
        en = 1'b1;
        data = $urandom;
        push_frame(data);
        trig_pulse(t_acc);
        idle(50);
        en = 1'b0;
        wait_done("t6_done", 1000);
        idle(10);
        check("t6_drained", exp_q.size(), 0);

        // Reset mid-frame, during the third byte (a zero payload byte).
        en = 1'b1;
        d = $urandom;
        d[15:8] = 8'h00;
        data = d;
        push_frame(data);
        trig_pulse(t_acc);
        idle(250);
        check("t5_tx_low_before_reset", {31'd0, tx}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("t5_tx_async", {31'd0, tx}, 32'd1);
        check("t5_busy_async", {31'd0, busy}, 32'd0);
        check("t5_overrun_cleared", {31'd0, ovr}, 32'd0);
        exp_q.delete();
        idle(3);
        rst = 1'b0;
        idle(5);
        data = $urandom;
        push_frame(data);
        trig_pulse(t_acc);
        wait_done("t5_done", 1000);
        idle(10);
        check("t5_drained", exp_q.size(), 0);
        check("t5_overrun_final", {31'd0, ovr}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
